// File: rtl/accumulator_nbit.sv
// Frame accumulator: sums frame_len unsigned operands per frame and presents
// the modulo-2^BIT_WIDTH sum plus a sticky carry-out flag with valid/ready handshake.
module accumulator_nbit #(
  parameter int unsigned BIT_WIDTH = 4,
  parameter int unsigned LEN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] frame_len,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_sum,
  output logic                 out_overflow,
  output logic                 busy
);

  localparam int unsigned SUM_WIDTH = BIT_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [BIT_WIDTH-1:0] sum_q, sum_d;
  logic                 sum_ovf_q, sum_ovf_d;
  logic [SUM_WIDTH-1:0] add_c;
  logic                 accept_c;

  // Carry-out of the top operand bit lands in add_c[BIT_WIDTH].
  assign add_c    = SUM_WIDTH'(acc_q) + SUM_WIDTH'(in_data);
  assign accept_c = (state_q == ACCUM) && in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      sum_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sum_q     <= sum_d;
      sum_ovf_q <= sum_ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    sum_d     = sum_q;
    sum_ovf_d = sum_ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          cnt_d   = frame_len;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept_c) begin
          acc_d = add_c[BIT_WIDTH-1:0];
          ovf_d = ovf_q | add_c[BIT_WIDTH];
          cnt_d = cnt_q - LEN_WIDTH'(1);
          // Last operand: capture the result so it survives the next frame's clear.
          if (cnt_q == LEN_WIDTH'(1)) begin
            sum_d     = add_c[BIT_WIDTH-1:0];
            sum_ovf_d = ovf_q | add_c[BIT_WIDTH];
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready     = (state_q == ACCUM);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign out_sum      = sum_q;
  assign out_overflow = sum_ovf_q;

endmodule

// File: tb/tb_accumulator_nbit.sv
// Directed bench for accumulator_nbit at BIT_WIDTH=4, LEN_WIDTH=4.
module tb_accumulator_nbit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] frame_len;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic       out_overflow;
  logic       busy;

  int total = 0;
  int bad   = 0;

  accumulator_nbit #(.BIT_WIDTH(4), .LEN_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .frame_len    (frame_len),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ir, input logic ov,
                            input logic [3:0] s, input logic of, input logic b);
    check({tag, ".in_ready"},     32'(in_ready),     32'(ir));
    check({tag, ".out_valid"},    32'(out_valid),    32'(ov));
    check({tag, ".out_sum"},      32'(out_sum),      32'(s));
    check({tag, ".out_overflow"}, 32'(out_overflow), 32'(of));
    check({tag, ".busy"},         32'(busy),         32'(b));
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; frame_len = 4'd3;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset for two cycles, with start held to show reset wins.
    tick(); tick();
    check_outs("reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0; start = 1'b0;

    // Basic frame: 1+2+3.
    start = 1'b1; frame_len = 4'd3; tick(); start = 1'b0;
    check_outs("basic_accum", 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data = 4'd1; tick();
    in_data = 4'd2; tick();
    check("basic_pre_last.out_valid", 32'(out_valid), 32'd0);
    in_data = 4'd3; tick();
    in_valid = 1'b0;
    check_outs("basic_done", 1'b0, 1'b1, 4'd6, 1'b0, 1'b1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check_outs("basic_idle", 1'b0, 1'b0, 4'd6, 1'b0, 1'b0);

    // Overflow with stalls: 9 + 8 = 17 -> sum 1, carry.
    start = 1'b1; frame_len = 4'd2; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 4'd9; tick();
    in_valid = 1'b0; in_data = 4'd7;
    tick(); tick();
    check_outs("ovf_stall", 1'b1, 1'b0, 4'd6, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = 4'd8; tick(); in_valid = 1'b0;
    check_outs("ovf_done", 1'b0, 1'b1, 4'd1, 1'b1, 1'b1);

    // Backpressure with start pulsed while DONE.
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); frame_len = 4'd5;
      tick();
      check_outs("bp_hold", 1'b0, 1'b1, 4'd1, 1'b1, 1'b1);
    end
    start = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check_outs("bp_release", 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);
    tick();
    check_outs("bp_stay_idle", 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);

    // Mid-frame reset, then a single-operand frame.
    start = 1'b1; frame_len = 4'd4; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 4'd15; tick();
    rst = 1'b1; out_ready = 1'b1; tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_outs("midrst", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    start = 1'b1; frame_len = 4'd1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 4'd5; tick(); in_valid = 1'b0;
    check_outs("len1_done", 1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Zero-length start is ignored.
    start = 1'b1; frame_len = 4'd0; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_outs("zero_len", 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
      tick();
    end

    // Maximum length: fifteen ones sum to 15 without carry.
    start = 1'b1; frame_len = 4'd15; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 4'd1;
    for (int i = 0; i < 14; i++) tick();
    check("max_pre_last.out_valid", 32'(out_valid), 32'd0);
    tick(); in_valid = 1'b0;
    check_outs("max_done", 1'b0, 1'b1, 4'd15, 1'b0, 1'b1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check_outs("max_idle", 1'b0, 1'b0, 4'd15, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
